// File: rtl/cpu_core_multicycle.sv
// cpu_core_multicycle: multi-cycle FETCH/EXEC/WB core with writable program memory and debug read port
// Ports: clk/rst (rising edge, async active-high reset); start launches execution at PC 0 from IDLE;
// prog_we/prog_addr/prog_data write program memory while IDLE; dbg_addr/dbg_data read any register;
// pc, state, halted, zero, result and result_valid expose architectural state.
module cpu_core_multicycle #(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 2,
    parameter int PC_W       = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    prog_we,
    input  logic [PC_W-1:0]         prog_addr,
    input  logic [3*REG_ADDR_W+2:0] prog_data,
    input  logic [REG_ADDR_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0]       dbg_data,
    output logic [PC_W-1:0]         pc,
    output logic [1:0]              state,
    output logic                    halted,
    output logic                    zero,
    output logic [DATA_W-1:0]       result,
    output logic                    result_valid
);
    localparam int INSTR_W = 3 + 3 * REG_ADDR_W;
    localparam int IMM_W   = 2 * REG_ADDR_W;
    localparam int NREG    = 2 ** REG_ADDR_W;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_EXEC = 2'd2, S_WB = 2'd3} state_t;

    state_t                state_q, state_d;
    logic [PC_W-1:0]       pc_q, pc_wb;
    logic [INSTR_W-1:0]    ir_q;
    logic [DATA_W-1:0]     alu_q, alu_d, result_q;
    logic                  halted_q, zero_q;
    logic [DATA_W-1:0]     regs_q [NREG];
    logic [INSTR_W-1:0]    imem [2**PC_W];

    logic [2:0]            op;
    logic [REG_ADDR_W-1:0] rd, rs1, rs2;
    logic [IMM_W-1:0]      imm;
    logic                  writes_rd, is_halt, take_target;

    assign {op, rd, rs1, rs2} = ir_q;
    assign imm         = {rs1, rs2};
    assign writes_rd   = op < 3'd6;
    assign is_halt     = op == 3'd7 && rd != '0;
    // JMP always redirects; BZ only when the flag from earlier instructions is set.
    // HALT also matches opcode 7 but its WB keeps pc, so it never uses pc_wb.
    assign take_target = op == 3'd7 || (op == 3'd6 && zero_q);
    assign pc_wb       = take_target ? PC_W'(imm) : pc_q + 1'b1;

    always_comb begin
        case (op)
            3'd0:    alu_d = regs_q[rs1] + regs_q[rs2];
            3'd1:    alu_d = regs_q[rs1] - regs_q[rs2];
            3'd2:    alu_d = regs_q[rs1] & regs_q[rs2];
            3'd3:    alu_d = regs_q[rs1] | regs_q[rs2];
            3'd4:    alu_d = regs_q[rs1] ^ regs_q[rs2];
            default: alu_d = DATA_W'(imm);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = start ? S_FETCH : S_IDLE;
            S_FETCH: state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = is_halt ? S_IDLE : S_FETCH;
        endcase
    end

    always_comb begin
        result_valid = state_q == S_WB && writes_rd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= '0;
            ir_q     <= '0;
            alu_q    <= '0;
            result_q <= '0;
            halted_q <= 1'b0;
            zero_q   <= 1'b0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    pc_q     <= '0;
                    halted_q <= 1'b0;
                end
                S_FETCH: ir_q <= imem[pc_q];
                S_EXEC:  alu_q <= alu_d;
                S_WB: begin
                    if (writes_rd) begin
                        regs_q[rd] <= alu_q;
                        result_q   <= alu_q;
                        zero_q     <= alu_q == '0;
                    end
                    if (is_halt) halted_q <= 1'b1;
                    else         pc_q     <= pc_wb;
                end
            endcase
        end
    end

    // Program memory has no reset so a loaded program survives a core reset.
    always_ff @(posedge clk) begin
        if (prog_we && state_q == S_IDLE) imem[prog_addr] <= prog_data;
    end

    assign dbg_data = regs_q[dbg_addr];
    assign pc       = pc_q;
    assign state    = state_q;
    assign halted   = halted_q;
    assign zero     = zero_q;
    assign result   = result_q;
endmodule

// File: doc/cpu_core_multicycle.md
# cpu_core_multicycle

Parametrised multi-cycle successor to the 8-bit single-cycle core. It fetches instructions from a writable program memory and executes them through an explicit FETCH/EXEC/WB state machine over a parametrised register file. It sits under the Tiny Tapeout top wrapper in place of the old core. New capabilities: subtract, XOR, load-immediate, a zero flag, conditional branch, halt, a program-load port and a debug register read port.

## Interface
Parameters:
- DATA_W, 8: datapath and register width.
- REG_ADDR_W, 2: register index width; register count is 2^REG_ADDR_W.
- PC_W, 4: PC width; program depth is 2^PC_W. Constraint: 2*REG_ADDR_W >= PC_W.
- INSTR_W (localparam), 3+3*REG_ADDR_W: instruction width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset rst, asynchronous, active-high; clock clk.
- start  in  1  leave IDLE/HALT and begin execution at PC 0.
- prog_we  in  1  program memory write strobe.
- prog_addr  in  PC_W  program write address.
- prog_data  in  INSTR_W  program write data.
- dbg_addr  in  REG_ADDR_W  debug register select.
- dbg_data  out  DATA_W  combinational read of regs[dbg_addr].
- pc  out  PC_W  current PC.
- state  out  2  IDLE=0, FETCH=1, EXEC=2, WB=3.
- halted  out  1  core stopped by HALT.
- zero  out  1  zero flag.
- result  out  DATA_W  value most recently written to a register.
- result_valid  out  1  high during a WB cycle that writes a register.

## Operation
Instruction fields, MSB first: opcode[3], rd, rs1, rs2 (each REG_ADDR_W bits). imm/target is {rs1,rs2}, zero-extended or truncated to DATA_W or PC_W.

Opcodes:
- 000 ADD: rd = rs1 + rs2.
- 001 SUB: rd = rs1 - rs2.
- 010 AND: rd = rs1 & rs2.
- 011 OR: rd = rs1 | rs2.
- 100 XOR: rd = rs1 ^ rs2.
- 101 LDI: rd = imm.
- 110 BZ: if zero, pc = target; else pc+1.
- 111 with rd==0 is JMP (pc = target). 111 with rd!=0 is HALT.

Arithmetic is modulo 2^DATA_W. Carry and borrow are discarded.

Flags and registers:
- zero is updated in WB by every register-writing opcode (000–101): zero = (written value == 0).
- BZ, JMP and HALT leave zero unchanged.
- All registers are general purpose; r0 is not hardwired.

State machine:
- IDLE: start=1 → FETCH, pc<=0.
- FETCH: ir <= imem[pc] → EXEC.
- EXEC: read rs1/rs2, latch ALU/imm result → WB.
- WB: write rd, update zero and result, update pc → FETCH. HALT instead sets halted=1, leaves pc unchanged and goes to IDLE.
- pc+1 wraps from 2^PC_W-1 to 0.

Start and program-load rules:
- start is honoured only in IDLE, whether or not halted. Honouring it clears halted and sets pc<=0. Registers and the zero flag are retained.
- start outside IDLE is ignored.
- prog_we is honoured only in IDLE; it is ignored otherwise. A write and start in the same IDLE cycle are both honoured; the write lands before the first FETCH.

Reset:
- Clears state=IDLE, pc=0, halted=0, zero=0, result=0, ir=0 and all registers.
- Program memory is not reset.
- A reset mid-instruction aborts it with no register write.

## Timing
- Every instruction takes exactly 3 cycles (FETCH, EXEC, WB), including branches.
- The start edge moves to FETCH on the next cycle.
- The first register write is visible on dbg_data 3 cycles after FETCH is entered.
- result_valid is combinational from (state==WB && opcode<=101).
- result and zero update at the edge ending WB.
- An instruction reading a register written by the previous instruction sees the new value, because WB completes before the next FETCH.
- A program of N instructions ending in HALT reaches halted=1 exactly 3N cycles after leaving IDLE.
- All outputs are 0 during and after reset, except dbg_data = regs value 0.

## Test plan
- Reset: assert rst mid-EXEC → state=0, pc=0, halted=0, zero=0, result=0, all dbg reads 0; program memory is unchanged.
- Basic program: load LDI r1,5; LDI r2,3; ADD r3,r1,r2; HALT(rd=1); pulse start → dbg r3=0x08, halted=1 12 cycles after leaving IDLE, pc=3.
- Wrap and flag: SUB r1,r0,r0? then LDI r2,1; SUB r1,r0,r2 → r1=0xFF; ADD r3,r1,r2 → r3=0x00, zero=1, result_valid pulses in each WB.
- Branch: LDI r1,4; SUB r2,r1,r1; BZ target 6 → pc=6 after BZ WB. With the operands nonzero, BZ falls through to pc=3.
- PC wrap: program with no HALT/JMP, 16 ALU ops → pc returns to 0 and execution continues.
- Gating: prog_we and start asserted during EXEC are ignored (memory and pc unchanged). After HALT, start restarts at pc 0 with registers retained.
